// File: rtl/sigma_fetch_if.sv
// sigma_fetch_if: request, sigma buffer port and coefficient stream of sigma_fetch
interface sigma_fetch_if #(
    parameter int DATA_W     = 8,
    parameter int ADDR_W     = 8,
    parameter int SLOT_SHIFT = 4
);
    logic                         start;
    logic [ADDR_W-SLOT_SHIFT-1:0] slot;
    logic [3:0]                   degree;
    logic                         rden;
    logic [ADDR_W-1:0]            rdaddress;
    logic [DATA_W-1:0]            q;
    logic                         wren;
    logic [ADDR_W-1:0]            wraddress;
    logic [DATA_W-1:0]            data;
    logic                         coef_valid;
    logic                         coef_ready;
    logic [DATA_W-1:0]            coef_data;
    logic [3:0]                   coef_idx;
    logic                         coef_last;
    logic                         busy;
    logic                         done;
    logic                         err;
    modport master (
        input  start, slot, degree, q, coef_ready,
        output rden, rdaddress, wren, wraddress, data,
               coef_valid, coef_data, coef_idx, coef_last, busy, done, err
    );
    modport slave (
        output start, slot, degree, q, coef_ready,
        input  rden, rdaddress, wren, wraddress, data,
               coef_valid, coef_data, coef_idx, coef_last, busy, done, err
    );
endinterface

// File: rtl/sigma_fetch.sv
// sigma_fetch: streams one slot of sigma coefficients from the buffer to Chien search.
// Define SIGMA_FETCH_CLEAR_EN to zero each entry as it is read (clear-on-read).
module sigma_fetch #(
    parameter int T          = 8,
    parameter int DATA_W     = 8,
    parameter int ADDR_W     = 8,
    parameter int SLOT_SHIFT = 4
) (
    input logic          clock,
    input logic          reset,
    sigma_fetch_if.master bus
);
    typedef enum logic [1:0] {IDLE, FETCH, DRAIN} state_t;
    state_t                       state;
    logic [ADDR_W-SLOT_SHIFT-1:0] slot_r;
    logic [3:0]                   deg_r, idx, infl_idx, i0, i1;
    logic [DATA_W-1:0]            d0, d1;
    logic [1:0]                   occ, wpos;
    logic                         inflight, valid, last, pop, issue, bad, done_r, err_r;
    logic [ADDR_W-1:0]            addr;

    assign valid = occ != 2'd0;
    assign last  = valid && i0 == deg_r;
    assign pop   = valid & bus.coef_ready;
    // occ + inflight - pop < 2, kept non-negative by moving pop to the right side
    assign issue = state == FETCH && idx <= deg_r && ({1'b0, occ} + {2'b0, inflight}) < 3'd2 + {2'b0, pop};
    assign addr  = {slot_r, {SLOT_SHIFT{1'b0}}} + ADDR_W'(idx);
    assign bad   = 32'(bus.degree) > 32'(T);
    assign wpos  = occ - {1'b0, pop};

    assign bus.rden       = issue;
    assign bus.rdaddress  = issue ? addr : '0;
    assign bus.coef_valid = valid;
    assign bus.coef_data  = d0;
    assign bus.coef_idx   = i0;
    assign bus.coef_last  = last;
    assign bus.busy       = state != IDLE;
    assign bus.done       = done_r;
    assign bus.err        = err_r;

    always_ff @(posedge clock) begin
        if (reset) begin
            state    <= IDLE;
            slot_r   <= '0;
            deg_r    <= '0;
            idx      <= '0;
            infl_idx <= '0;
            inflight <= 1'b0;
            occ      <= '0;
            d0       <= '0;
            d1       <= '0;
            i0       <= '0;
            i1       <= '0;
            done_r   <= 1'b0;
            err_r    <= 1'b0;
        end else begin
            done_r   <= 1'b0;
            inflight <= issue;
            infl_idx <= idx;
            if (issue) idx <= idx + 4'd1;
            if (pop) begin
                d0 <= d1;
                i0 <= i1;
            end
            // returned word lands behind whatever survives this cycle's pop
            if (inflight && wpos == 2'd0) begin
                d0 <= bus.q;
                i0 <= infl_idx;
            end else if (inflight) begin
                d1 <= bus.q;
                i1 <= infl_idx;
            end
            occ <= occ + {1'b0, inflight} - {1'b0, pop};
            if (state == IDLE && bus.start) begin
                slot_r <= bus.slot;
                deg_r  <= bus.degree;
                idx    <= '0;
                err_r  <= bad;
                done_r <= bad;
                state  <= bad ? IDLE : FETCH;
            end
            if (state == FETCH && issue && idx == deg_r) state <= DRAIN;
            if (state == DRAIN && pop && last) begin
                state  <= IDLE;
                done_r <= 1'b1;
            end
        end
    end

`ifdef SIGMA_FETCH_CLEAR_EN
    logic [ADDR_W-1:0] infl_addr;
    always_ff @(posedge clock) begin
        if (reset) infl_addr <= '0;
        else infl_addr <= addr;
    end
    assign bus.wren      = inflight;
    assign bus.wraddress = inflight ? infl_addr : '0;
    assign bus.data      = '0;
`else
    assign bus.wren      = 1'b0;
    assign bus.wraddress = '0;
    assign bus.data      = '0;
`endif
endmodule

// File: tb/tb_sigma_fetch.sv
// tb_sigma_fetch: table-driven timing vectors plus back-pressure, reset and clear-on-read sequences.
module tb_sigma_fetch;
    logic clock = 1'b0;
    logic reset = 1'b1;
    int   checks = 0;
    int   errors = 0;

    always #5 clock = ~clock;

    sigma_fetch_if #(.DATA_W(8), .ADDR_W(8), .SLOT_SHIFT(4)) bus ();
    sigma_fetch #(.T(8), .DATA_W(8), .ADDR_W(8), .SLOT_SHIFT(4)) dut (
        .clock(clock),
        .reset(reset),
        .bus  (bus)
    );

    function automatic logic [7:0] init_val(input int a);
        case (a)
            'h20, 'h50: return 8'hA1;
            'h21, 'h51: return 8'hB2;
            'h22, 'h52: return 8'hC3;
            'h23, 'h53: return 8'hD4;
            'hF0:       return 8'h5A;
            'hE0:       return 8'h6B;
            'h60:       return 8'h61;
            'h61:       return 8'h62;
            'h10:       return 8'h11;
            'h11:       return 8'h22;
            'h12:       return 8'h33;
            default:    return (a >= 'h40 && a < 'h50) ? 8'(a + 'h40) : 8'hEE;
        endcase
    endfunction

    // sigma buffer model: one-cycle read latency, reloaded on reset
    logic [7:0] mem [256];
    always @(posedge clock) begin
        if (reset) for (int i = 0; i < 256; i++) mem[i] <= init_val(i);
        else if (bus.wren) mem[bus.wraddress] <= bus.data;
        if (bus.rden) bus.q <= mem[bus.rdaddress];
    end

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic chk_zero(input string nm);
        chk({nm, "_rden"}, int'(bus.rden), 0);
        chk({nm, "_rdaddress"}, int'(bus.rdaddress), 0);
        chk({nm, "_wren"}, int'(bus.wren), 0);
        chk({nm, "_wraddress"}, int'(bus.wraddress), 0);
        chk({nm, "_data"}, int'(bus.data), 0);
        chk({nm, "_coef_valid"}, int'(bus.coef_valid), 0);
        chk({nm, "_coef_data"}, int'(bus.coef_data), 0);
        chk({nm, "_coef_idx"}, int'(bus.coef_idx), 0);
        chk({nm, "_coef_last"}, int'(bus.coef_last), 0);
        chk({nm, "_busy"}, int'(bus.busy), 0);
        chk({nm, "_done"}, int'(bus.done), 0);
        chk({nm, "_err"}, int'(bus.err), 0);
    endtask

    // one fetch with a repeating 6-cycle ready pattern, scoreboarded against the buffer model
    task automatic run_fetch(input int s, input int d, input logic [5:0] pat, input bit zeroed);
        int issued = 0, popped = 0, pa, got_done = 0, paddr = 0, pd = 0, pi = 0;
        logic pr = 1'b0, prv = 1'b0, prr = 1'b1;
        @(negedge clock);
        bus.start = 1'b1;
        bus.slot = 4'(s);
        bus.degree = 4'(d);
        bus.coef_ready = 1'b1;
        for (int c = 0; c < 60 && got_done == 0; c++) begin
            @(negedge clock);
            bus.start = 1'b0;
            bus.coef_ready = pat[c % 6];
            #1;
            pa = int'(bus.coef_valid & bus.coef_ready);
            if (bus.rden) begin
                chk("rden_overflow", int'(issued - popped - pa < 2), 1);
                chk("rdaddress", int'(bus.rdaddress), s * 16 + issued);
            end
`ifdef SIGMA_FETCH_CLEAR_EN
            chk("wren", int'(bus.wren), int'(pr));
            if (pr) begin
                chk("wraddress", int'(bus.wraddress), paddr);
                chk("wdata", int'(bus.data), 0);
            end
`else
            chk("wren_off", int'(bus.wren), 0);
`endif
            if (prv && !prr) begin
                chk("hold_valid", int'(bus.coef_valid), 1);
                chk("hold_data", int'(bus.coef_data), pd);
                chk("hold_idx", int'(bus.coef_idx), pi);
            end
            if (pa != 0) begin
                chk("coef_data", int'(bus.coef_data), zeroed ? 0 : int'(init_val(s * 16 + popped)));
                chk("coef_idx", int'(bus.coef_idx), popped);
                chk("coef_last", int'(bus.coef_last), int'(popped == d));
            end
            if (bus.done) begin
                got_done = 1;
                chk("busy_at_done", int'(bus.busy), 0);
            end
            issued += int'(bus.rden);
            popped += pa;
            pr = bus.rden;
            paddr = int'(bus.rdaddress);
            prv = bus.coef_valid;
            prr = bus.coef_ready;
            pd = int'(bus.coef_data);
            pi = int'(bus.coef_idx);
        end
        chk("done_seen", got_done, 1);
        chk("coef_count", popped, d + 1);
    endtask

    typedef struct {
        int st, sl, dg, rdy;
        int rden, addr, v, cd, ci, cl, busy, done, err;
    } vec_t;
    vec_t tbl [21];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected $finish");
        $fatal(1);
    end

    initial begin
        tbl[0]  = '{1, 2, 3, 1,  0, 0,     0, 0,     0, 0, 0, 0, 0};
        tbl[1]  = '{0, 0, 0, 1,  1, 'h20,  0, 0,     0, 0, 1, 0, 0};
        tbl[2]  = '{0, 0, 0, 1,  1, 'h21,  0, 0,     0, 0, 1, 0, 0};
        tbl[3]  = '{0, 0, 0, 1,  1, 'h22,  1, 'hA1,  0, 0, 1, 0, 0};
        tbl[4]  = '{0, 0, 0, 1,  1, 'h23,  1, 'hB2,  1, 0, 1, 0, 0};
        tbl[5]  = '{0, 0, 0, 1,  0, 0,     1, 'hC3,  2, 0, 1, 0, 0};
        tbl[6]  = '{0, 0, 0, 1,  0, 0,     1, 'hD4,  3, 1, 1, 0, 0};
        tbl[7]  = '{0, 0, 0, 1,  0, 0,     0, 0,     0, 0, 0, 1, 0};
        tbl[8]  = '{1, 15, 0, 1, 0, 0,     0, 0,     0, 0, 0, 0, 0};
        tbl[9]  = '{0, 0, 0, 1,  1, 'hF0,  0, 0,     0, 0, 1, 0, 0};
        tbl[10] = '{0, 0, 0, 1,  0, 0,     0, 0,     0, 0, 1, 0, 0};
        tbl[11] = '{0, 0, 0, 1,  0, 0,     1, 'h5A,  0, 1, 1, 0, 0};
        tbl[12] = '{0, 0, 0, 1,  0, 0,     0, 0,     0, 0, 0, 1, 0};
        tbl[13] = '{1, 3, 9, 1,  0, 0,     0, 0,     0, 0, 0, 0, 0};
        tbl[14] = '{0, 0, 0, 1,  0, 0,     0, 0,     0, 0, 0, 1, 1};
        tbl[15] = '{0, 0, 0, 1,  0, 0,     0, 0,     0, 0, 0, 0, 1};
        tbl[16] = '{1, 14, 0, 1, 0, 0,     0, 0,     0, 0, 0, 0, 1};
        tbl[17] = '{0, 0, 0, 1,  1, 'hE0,  0, 0,     0, 0, 1, 0, 0};
        tbl[18] = '{0, 0, 0, 1,  0, 0,     0, 0,     0, 0, 1, 0, 0};
        tbl[19] = '{0, 0, 0, 1,  0, 0,     1, 'h6B,  0, 1, 1, 0, 0};
        tbl[20] = '{0, 0, 0, 1,  0, 0,     0, 0,     0, 0, 0, 1, 0};
        bus.start = 1'b0;
        bus.slot = '0;
        bus.degree = '0;
        bus.coef_ready = 1'b0;
        repeat (2) @(posedge clock);
        @(negedge clock);
        #1;
        chk_zero("reset");
        reset = 1'b0;
        for (int k = 0; k < 21; k++) begin
            @(negedge clock);
            bus.start = 1'(tbl[k].st);
            bus.slot = 4'(tbl[k].sl);
            bus.degree = 4'(tbl[k].dg);
            bus.coef_ready = 1'(tbl[k].rdy);
            #1;
            chk($sformatf("row%0d_rden", k), int'(bus.rden), tbl[k].rden);
            chk($sformatf("row%0d_rdaddress", k), int'(bus.rdaddress), tbl[k].addr);
            chk($sformatf("row%0d_coef_valid", k), int'(bus.coef_valid), tbl[k].v);
            if (tbl[k].v != 0) begin
                chk($sformatf("row%0d_coef_data", k), int'(bus.coef_data), tbl[k].cd);
                chk($sformatf("row%0d_coef_idx", k), int'(bus.coef_idx), tbl[k].ci);
                chk($sformatf("row%0d_coef_last", k), int'(bus.coef_last), tbl[k].cl);
            end
            chk($sformatf("row%0d_busy", k), int'(bus.busy), tbl[k].busy);
            chk($sformatf("row%0d_done", k), int'(bus.done), tbl[k].done);
            chk($sformatf("row%0d_err", k), int'(bus.err), tbl[k].err);
`ifndef SIGMA_FETCH_CLEAR_EN
            chk($sformatf("row%0d_wren", k), int'(bus.wren), 0);
`endif
        end
        bus.start = 1'b0;
        run_fetch(5, 3, 6'b101001, 1'b0);
        @(negedge clock);
        bus.start = 1'b1;
        bus.slot = 4'd4;
        bus.degree = 4'd8;
        bus.coef_ready = 1'b1;
        @(negedge clock);
        bus.start = 1'b0;
        repeat (3) @(negedge clock);
        #1;
        chk("busy_before_reset", int'(bus.busy), 1);
        reset = 1'b1;
        @(negedge clock);
        #1;
        chk_zero("reset_mid");
        reset = 1'b0;
        run_fetch(6, 1, 6'b111111, 1'b0);
        run_fetch(1, 2, 6'b111111, 1'b0);
`ifdef SIGMA_FETCH_CLEAR_EN
        run_fetch(1, 2, 6'b111111, 1'b1);
`else
        run_fetch(1, 2, 6'b111111, 1'b0);
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
